data_cache: RTL and testbench
=============================

// Module: data_cache
// PURPOSE
// - Direct-mapped, write-back, write-allocate data cache between the single-cycle core's ALU
//   load/store port and byte-organised data memory (4 bytes per word).
// - On a miss it raises a stall request (interupt_second for writeback, interupt_start for fill).
// - The core counts the memory latency and pulses interupt_stop to end each memory phase.
// PARAMETERS
// - NUM_LINES  32  number of one-word lines (power of two); INDEX_W = log2(NUM_LINES)
// PORTS
// - clk              in   1      single clock, all state on posedge
// - rst_b            in   1      reset, asynchronous, ACTIVE-HIGH despite the name
// - opcode           in   7      current instr opcode; 7'h03 = load, 7'h23 = store, else no access
// - cache_addr       in   32     byte address from ALU (word aligned, [1:0] ignored)
// - cache_we         in   1      1 = store request (qualified by opcode 7'h23)
// - cache_data_in    in   8x4    store data bytes [0:3], byte 0 = addr+0
// - cache_data_out   out  8x4    load data bytes [0:3]
// - cache_hit        out  1      access hits a valid line with matching tag
// - interupt_start   out  1      fill phase active (core stalls)
// - interupt_second  out  1      writeback phase active (core stalls)
// - interupt_stop    in   1      one-cycle pulse from core: current memory phase complete
// - mem_addr         out  32     word address to memory
// - mem_data_in      out  8x4    data to memory (victim line)
// - mem_data_out     in   8x4    data from memory (combinational read of mem_addr)
// - mem_we           out  1      memory write enable
// BEHAVIOUR
// - Address split: offset [1:0], index [INDEX_W+1:2], tag [31:INDEX_W+2]
// - Per line: valid, dirty, tag, 4 data bytes
// - access = (opcode==7'h03) | (opcode==7'h23)
// - cache_hit = access & valid[idx] & (tag[idx]==addr tag)
//   - combinational; 0 when no access
// - cache_data_out = line data of idx (combinational)
//   - meaningful only when cache_hit=1; 0 while in reset
// - FSM states: IDLE, WB, FILL
// - IDLE
//   - Hit on store (cache_we=1): write 4 bytes on posedge, set dirty. Hit on load: no state change.
//   - Miss with valid & dirty victim: -> WB.
//   - Miss otherwise: -> FILL.
//   - Transition takes effect on the posedge where the miss is seen.
// - WB
//   - interupt_second=1, mem_we=1
//   - mem_addr = {victim tag, idx, 2'b00}, mem_data_in = victim bytes
//   - On posedge with interupt_stop=1: clear dirty[idx], -> FILL
// - FILL
//   - interupt_start=1, mem_we=0, mem_addr = {addr[31:2], 2'b00}
//   - On posedge with interupt_stop=1: line <= mem_data_out, tag <= addr tag, valid=1,
//     dirty=0, -> IDLE
//   - Next cycle the access hits; a store then writes and sets dirty as a normal hit.
// - interupt_start and interupt_second are never both 1; both are 0 in IDLE.
// - interupt_stop in IDLE is ignored.
// - cache_addr/opcode/cache_data_in are held stable by the stalled core during WB/FILL.
// - mem_addr outside WB/FILL = {cache_addr[31:2], 2'b00}; mem_data_in = 0; mem_we = 0.
// - Reset (async, rst_b=1)
//   - all valid/dirty cleared, state IDLE
//   - interupt_start = interupt_second = mem_we = 0, cache_hit = 0
//   - Reset mid-WB/FILL aborts the phase; the memory write is dropped.
// - No write-through: memory is updated only by victim writeback.
// TESTING
// - Reset, then load 0x100 with mem[0x100]=DE AD BE EF -> cache_hit=0, interupt_start=1,
//   mem_addr=0x100, mem_we=0. After interupt_stop pulse -> cache_hit=1, data_out=DE AD BE EF.
// - Store 0x11223344 bytes to 0x100 (line valid) -> hit, no stall, next load returns the new
//   bytes; memory unchanged.
// - Load 0x180 (NUM_LINES=32, same index as 0x100, dirty) -> interupt_second=1, mem_we=1,
//   mem_addr=0x100, mem_data_in=stored bytes. Stop -> FILL at 0x180. Stop -> hit.
// - Load a conflicting clean line -> straight to FILL, no WB phase, mem_we stays 0.
// - Opcode 7'h33 with any address -> cache_hit=0, no stall, state unchanged.
// - Assert rst_b during FILL -> interupt_start=0 immediately; later load of same address misses.

Source files
------------

// File: rtl/data_cache_if.sv
// data_cache_if
// Bundles the core-side load/store port and the memory-side port of the
// data cache. The cache connects through the slave modport; the core/memory
// environment drives through the master modport.
//
// Stall handshake: the cache raises interupt_second (writeback) or
// interupt_start (fill) and holds it steady until the core returns a
// one-cycle interupt_stop pulse; the phase ends on the posedge that samples
// interupt_stop=1. While a phase is active the core holds opcode,
// cache_addr, cache_we and cache_data_in stable.
//
// Signals
//   opcode          core -> cache  7'h03 load, 7'h23 store, else no access
//   cache_addr      core -> cache  byte address, [1:0] ignored
//   cache_we        core -> cache  store request
//   cache_data_in   core -> cache  store bytes, element 0 = addr+0
//   cache_data_out  cache -> core  load bytes of the indexed line
//   cache_hit       cache -> core  access hits a valid matching line
//   interupt_start  cache -> core  fill phase active
//   interupt_second cache -> core  writeback phase active
//   interupt_stop   core -> cache  current memory phase complete
//   mem_addr        cache -> mem   word address
//   mem_data_in     cache -> mem   victim bytes
//   mem_data_out    mem -> cache   combinational read of mem_addr
//   mem_we          cache -> mem   write enable
//   dbg_state       cache -> any   FSM state for observation
interface data_cache_if;
  logic [6:0]       opcode;
  logic [31:0]      cache_addr;
  logic             cache_we;
  logic [0:3][7:0]  cache_data_in;
  logic [0:3][7:0]  cache_data_out;
  logic             cache_hit;
  logic             interupt_start;
  logic             interupt_second;
  logic             interupt_stop;
  logic [31:0]      mem_addr;
  logic [0:3][7:0]  mem_data_in;
  logic [0:3][7:0]  mem_data_out;
  logic             mem_we;
  logic [1:0]       dbg_state;

  modport slave (
    input  opcode, cache_addr, cache_we, cache_data_in, interupt_stop, mem_data_out,
    output cache_data_out, cache_hit, interupt_start, interupt_second,
           mem_addr, mem_data_in, mem_we, dbg_state
  );

  modport master (
    output opcode, cache_addr, cache_we, cache_data_in, interupt_stop, mem_data_out,
    input  cache_data_out, cache_hit, interupt_start, interupt_second,
           mem_addr, mem_data_in, mem_we, dbg_state
  );
endinterface

// File: rtl/data_cache.sv
// data_cache
// Direct-mapped, write-back, write-allocate cache of NUM_LINES one-word lines
// between the core's load/store port and byte-organised data memory.
// A miss stalls the core: a dirty victim is first written back (WB phase,
// interupt_second), then the requested word is fetched (FILL phase,
// interupt_start). The core times memory latency and ends each phase with
// interupt_stop.
//
// Ports
//   clk    in  clock, all state on posedge
//   rst_b  in  asynchronous reset, active high
//   bus    slave modport of data_cache_if (core and memory signals)
module data_cache #(
  parameter int NUM_LINES = 32
) (
  input  logic         clk,
  input  logic         rst_b,
  data_cache_if.slave  bus
);
  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 32 - INDEX_W - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   int_start_q;
  logic                   int_second_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic [NUM_LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [0:3][7:0]        data_q [NUM_LINES];

  logic [INDEX_W-1:0]     idx;
  logic [TAG_W-1:0]       addr_tag;
  logic                   access;
  logic                   store_req;
  logic                   hit_raw;
  logic                   unused_addr_bits;

  assign idx       = bus.cache_addr[INDEX_W+1:2];
  assign addr_tag  = bus.cache_addr[31:INDEX_W+2];
  assign access    = (bus.opcode == 7'h03) || (bus.opcode == 7'h23);
  assign store_req = (bus.opcode == 7'h23) && bus.cache_we;
  assign hit_raw   = access && valid_q[idx] && (tag_q[idx] == addr_tag);

  // Byte offset is irrelevant for one-word lines.
  assign unused_addr_bits = ^bus.cache_addr[1:0];

  assign bus.cache_hit      = !rst_b && hit_raw;
  assign bus.cache_data_out = rst_b ? '0 : data_q[idx];

  assign bus.interupt_start  = int_start_q;
  assign bus.interupt_second = int_second_q;
  assign bus.mem_we          = int_second_q;
  assign bus.dbg_state       = state_q;

  // Memory port: victim address/data during writeback, the requested word
  // address otherwise; write data is forced to zero outside writeback.
  always_comb begin
    bus.mem_addr    = {bus.cache_addr[31:2], 2'b00};
    bus.mem_data_in = '0;
    if (state_q == S_WB) begin
      bus.mem_addr    = {tag_q[idx], idx, 2'b00};
      bus.mem_data_in = data_q[idx];
    end
  end

  // Control FSM with registered stall outputs.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q      <= S_IDLE;
      int_start_q  <= 1'b0;
      int_second_q <= 1'b0;
      valid_q      <= '0;
      dirty_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (access && !hit_raw) begin
            if (valid_q[idx] && dirty_q[idx]) begin
              state_q      <= S_WB;
              int_second_q <= 1'b1;
            end else begin
              state_q     <= S_FILL;
              int_start_q <= 1'b1;
            end
          end else if (hit_raw && store_req) begin
            dirty_q[idx] <= 1'b1;
          end
        end
        S_WB: begin
          if (bus.interupt_stop) begin
            dirty_q[idx] <= 1'b0;
            state_q      <= S_FILL;
            int_second_q <= 1'b0;
            int_start_q  <= 1'b1;
          end
        end
        S_FILL: begin
          if (bus.interupt_stop) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            state_q      <= S_IDLE;
            int_start_q  <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          int_start_q  <= 1'b0;
          int_second_q <= 1'b0;
        end
      endcase
    end
  end

  // Line storage needs no reset: valid bits gate every use. Writes only occur
  // from IDLE or FILL, and reset forces IDLE with all lines invalid, so a
  // reset-time edge cannot write a line.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && hit_raw && store_req) begin
      data_q[idx] <= bus.cache_data_in;
    end else if (state_q == S_FILL && bus.interupt_stop) begin
      data_q[idx] <= bus.mem_data_out;
      tag_q[idx]  <= addr_tag;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_cache_if bus();

  data_cache #(.NUM_LINES(32)) dut (
    .clk   (clk),
    .rst_b (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- word memory (byte 0 = MSB of the word) ----------------
  logic [31:0] mem_arr [0:1023];
  assign bus.mem_data_out = mem_arr[bus.mem_addr[11:2]];

  always @(posedge clk) begin
    if (!rst && bus.mem_we && bus.interupt_stop)
      mem_arr[bus.mem_addr[11:2]] <= bus.mem_data_in;
  end

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0;
  localparam int PH_WB   = 1;
  localparam int PH_FILL = 2;

  logic        mv   [32];
  logic        md   [32];
  logic [24:0] mt   [32];
  logic [31:0] mdat [32];
  int          ph;

  function automatic int m_idx();
    return int'(bus.cache_addr[6:2]);
  endfunction

  function automatic logic m_access();
    return (bus.opcode == 7'h03) || (bus.opcode == 7'h23);
  endfunction

  function automatic logic m_hit();
    int i;
    i = m_idx();
    return m_access() && mv[i] && (mt[i] == bus.cache_addr[31:7]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mv[i] <= 1'b0;
        md[i] <= 1'b0;
      end
      ph <= PH_IDLE;
    end else begin
      if (ph == PH_IDLE) begin
        if (m_hit()) begin
          if (bus.opcode == 7'h23 && bus.cache_we) begin
            mdat[m_idx()] <= bus.cache_data_in;
            md[m_idx()]   <= 1'b1;
          end
        end else if (m_access()) begin
          ph <= (mv[m_idx()] && md[m_idx()]) ? PH_WB : PH_FILL;
        end
      end else if (ph == PH_WB) begin
        if (bus.interupt_stop) begin
          md[m_idx()] <= 1'b0;
          ph <= PH_FILL;
        end
      end else begin
        if (bus.interupt_stop) begin
          mdat[m_idx()] <= mem_arr[bus.cache_addr[11:2]];
          mt[m_idx()]   <= bus.cache_addr[31:7];
          mv[m_idx()]   <= 1'b1;
          md[m_idx()]   <= 1'b0;
          ph <= PH_IDLE;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_hit", 32'(bus.cache_hit), 32'd0);
      chk("rst_start", 32'(bus.interupt_start), 32'd0);
      chk("rst_second", 32'(bus.interupt_second), 32'd0);
      chk("rst_we", 32'(bus.mem_we), 32'd0);
      chk("rst_dout", bus.cache_data_out, 32'd0);
    end else begin
      int i;
      logic [31:0] e_addr;
      logic [31:0] e_din;
      i = m_idx();
      e_addr = {bus.cache_addr[31:2], 2'b00};
      e_din  = 32'd0;
      if (ph == PH_WB) begin
        e_addr = {mt[i], 5'(i), 2'b00};
        e_din  = mdat[i];
      end
      chk("cyc_hit", 32'(bus.cache_hit), 32'(m_hit()));
      if (m_hit()) chk("cyc_dout", bus.cache_data_out, mdat[i]);
      chk("cyc_start", 32'(bus.interupt_start), 32'(ph == PH_FILL));
      chk("cyc_second", 32'(bus.interupt_second), 32'(ph == PH_WB));
      chk("cyc_we", 32'(bus.mem_we), 32'(ph == PH_WB));
      chk("cyc_maddr", bus.mem_addr, e_addr);
      chk("cyc_mdin", bus.mem_data_in, e_din);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [6:0] op, input logic [31:0] addr,
                       input logic we, input logic [31:0] d);
    @(negedge clk);
    #1;
    bus.opcode        = op;
    bus.cache_addr    = addr;
    bus.cache_we      = we;
    bus.cache_data_in = d;
    #1;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    #1 bus.interupt_stop = 1'b1;
    @(negedge clk);
    #1 bus.interupt_stop = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.opcode        = 7'h00;
    bus.cache_addr    = 32'h0;
    bus.cache_we      = 1'b0;
    bus.cache_data_in = 32'h0;
    bus.interupt_stop = 1'b0;
    for (int i = 0; i < 1024; i++) mem_arr[i] = 32'h0;
    mem_arr[32'h100 >> 2] = 32'hDEADBEEF;
    mem_arr[32'h180 >> 2] = 32'hCAFEF00D;
    mem_arr[32'h200 >> 2] = 32'h0BADCAFE;
    mem_arr[32'h280 >> 2] = 32'h55667788;

    repeat (3) @(negedge clk);
    chk("reset_hit", 32'(bus.cache_hit), 32'd0);
    chk("reset_start", 32'(bus.interupt_start), 32'd0);
    #1 rst = 1'b0;

    // Cold load miss -> FILL.
    drive(7'h03, 32'h100, 1'b0, 32'h0);
    chk("cold_hit", 32'(bus.cache_hit), 32'd0);
    @(negedge clk);
    chk("cold_start", 32'(bus.interupt_start), 32'd1);
    chk("cold_maddr", bus.mem_addr, 32'h100);
    chk("cold_we", 32'(bus.mem_we), 32'd0);
    pulse_stop();
    @(negedge clk);
    chk("cold_hit_after", 32'(bus.cache_hit), 32'd1);
    chk("cold_data", bus.cache_data_out, 32'hDEADBEEF);

    // Store hit: no stall, memory untouched.
    drive(7'h23, 32'h100, 1'b1, 32'h11223344);
    chk("st_hit", 32'(bus.cache_hit), 32'd1);
    @(negedge clk);
    chk("st_nostall", 32'(bus.interupt_start | bus.interupt_second), 32'd0);
    drive(7'h03, 32'h100, 1'b0, 32'h0);
    chk("st_readback", bus.cache_data_out, 32'h11223344);
    chk("st_mem_kept", mem_arr[32'h100 >> 2], 32'hDEADBEEF);

    // Conflict with dirty line -> WB then FILL.
    drive(7'h03, 32'h180, 1'b0, 32'h0);
    @(negedge clk);
    chk("wb_second", 32'(bus.interupt_second), 32'd1);
    chk("wb_start", 32'(bus.interupt_start), 32'd0);
    chk("wb_we", 32'(bus.mem_we), 32'd1);
    chk("wb_maddr", bus.mem_addr, 32'h100);
    chk("wb_mdin", bus.mem_data_in, 32'h11223344);
    pulse_stop();
    @(negedge clk);
    chk("wbf_start", 32'(bus.interupt_start), 32'd1);
    chk("wbf_second", 32'(bus.interupt_second), 32'd0);
    chk("wbf_maddr", bus.mem_addr, 32'h180);
    chk("wbf_we", 32'(bus.mem_we), 32'd0);
    chk("wb_mem_written", mem_arr[32'h100 >> 2], 32'h11223344);
    pulse_stop();
    @(negedge clk);
    chk("wbf_hit", 32'(bus.cache_hit), 32'd1);
    chk("wbf_data", bus.cache_data_out, 32'hCAFEF00D);

    // Conflict with clean line -> straight to FILL.
    drive(7'h03, 32'h200, 1'b0, 32'h0);
    @(negedge clk);
    chk("cl_start", 32'(bus.interupt_start), 32'd1);
    chk("cl_second", 32'(bus.interupt_second), 32'd0);
    chk("cl_we", 32'(bus.mem_we), 32'd0);
    pulse_stop();
    @(negedge clk);
    chk("cl_data", bus.cache_data_out, 32'h0BADCAFE);
    chk("cl_mem_kept", mem_arr[32'h180 >> 2], 32'hCAFEF00D);

    // Non-memory opcode: no hit, no stall; stop in IDLE ignored.
    drive(7'h33, 32'h200, 1'b0, 32'h0);
    chk("nop_hit", 32'(bus.cache_hit), 32'd0);
    pulse_stop();
    @(negedge clk);
    chk("nop_stall", 32'(bus.interupt_start | bus.interupt_second), 32'd0);
    drive(7'h33, 32'h300, 1'b1, 32'hFFFFFFFF);
    @(negedge clk);
    chk("nop2_stall", 32'(bus.interupt_start | bus.interupt_second), 32'd0);
    drive(7'h03, 32'h200, 1'b0, 32'h0);
    chk("nop_line_kept", bus.cache_data_out, 32'h0BADCAFE);

    // Store miss allocates, then writes as a hit.
    drive(7'h23, 32'h184, 1'b1, 32'hA1B2C3D4);
    chk("sm_hit", 32'(bus.cache_hit), 32'd0);
    @(negedge clk);
    chk("sm_start", 32'(bus.interupt_start), 32'd1);
    pulse_stop();
    @(negedge clk);
    chk("sm_data", bus.cache_data_out, 32'hA1B2C3D4);
    drive(7'h03, 32'h184, 1'b0, 32'h0);
    chk("sm_readback", bus.cache_data_out, 32'hA1B2C3D4);
    chk("sm_mem_kept", mem_arr[32'h184 >> 2], 32'h0);

    // Reset in the middle of FILL.
    drive(7'h03, 32'h280, 1'b0, 32'h0);
    @(negedge clk);
    chk("rf_start", 32'(bus.interupt_start), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rf_start_drop", 32'(bus.interupt_start), 32'd0);
    chk("rf_dout", bus.cache_data_out, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rf_miss", 32'(bus.cache_hit), 32'd0);
    @(negedge clk);
    chk("rf_refill", 32'(bus.interupt_start), 32'd1);
    pulse_stop();
    @(negedge clk);
    chk("rf_data", bus.cache_data_out, 32'h55667788);
    drive(7'h03, 32'h184, 1'b0, 32'h0);
    chk("rf_invalidated", 32'(bus.cache_hit), 32'd0);
    pulse_stop();

    drive(7'h00, 32'h0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
